serial_add_ctrl: RTL and testbench

//   Bit-serial sequencer for the single-bit full_adder cell. Accepts two

---
 rtl/serial_add_ctrl.sv | 150 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial sequencer for a single shared full_adder cell.
// Operands and carry-in are captured on an accepted start. One bit pair is
// presented to the cell per cycle, LSB first, and the carry is chained through
// an internal flop. The WIDTH-bit sum and the final carry-out are assembled
// from the cell's outputs.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // Shift right by one and insert a new bit at the MSB; also valid for WIDTH=1.
    function automatic logic [WIDTH-1:0] shift_in_msb(input logic [WIDTH-1:0] v,
                                                      input logic             b);
        logic [WIDTH-1:0] r;
        r            = v >> 1;
        r[WIDTH-1]   = b;
        return r;
    endfunction

    // Drive the shared cell only while an addition is in flight.
    always_comb begin
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state_q == ST_RUN) begin
            fa_a   = a_sh_q[0];
            fa_b   = b_sh_q[0];
            fa_cin = carry_q;
        end
    end

    // Next-state and datapath update; abort freezes the datapath where it is.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    sum_d   = shift_in_msb(sum_q, fa_sum);
                    carry_d = fa_cout;
                    a_sh_d  = a_sh_q >> 1;
                    b_sh_d  = b_sh_q >> 1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cout_d  = fa_cout;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Single state register for control and datapath, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit and a 1-bit instance, each wired to a
// behavioural full adder; results are checked against plain integer addition.
module tb_serial_add_ctrl;

    logic clk;
    logic rst;

    // 8-bit instance
    logic       start8, abort8, cin8;
    logic [7:0] op_a8, op_b8, sum8;
    logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
    logic       busy8, done8, cout8;

    // 1-bit instance
    logic       start1, abort1, cin1;
    logic [0:0] op_a1, op_b1, sum1;
    logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;
    logic       busy1, done1, cout1;

    int n_cmp;
    int n_fail;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .op_a(op_a8), .op_b(op_b8), .cin(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8),
        .fa_sum(fa_sum8), .fa_cout(fa_cout8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .op_a(op_a1), .op_b(op_b1), .cin(cin1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
        .fa_sum(fa_sum1), .fa_cout(fa_cout1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Behavioural full adder cells
    assign {fa_cout8, fa_sum8} = 2'(fa_a8) + 2'(fa_b8) + 2'(fa_cin8);
    assign {fa_cout1, fa_sum1} = 2'(fa_a1) + 2'(fa_b1) + 2'(fa_cin1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run one 8-bit addition from an IDLE cycle; returns in the IDLE cycle after done.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat, output logic [7:0] s, output logic co,
                          output logic fcin_first, output logic busy_at_done,
                          output logic post_ok);
        int cyc;
        op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        fcin_first = fa_cin8;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        lat = (done8 === 1'b1) ? cyc + 1 : -1;
        s = sum8;
        co = cout8;
        busy_at_done = busy8;
        @(posedge clk); #1;
        post_ok = (done8 === 1'b0) && (busy8 === 1'b0) && (sum8 === s) && (cout8 === co);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            $display("FAIL reset_ctrl8: busy=%b done=%b want 0 0", busy8, done8); n_fail++;
        end
        n_cmp++;
        if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
            $display("FAIL reset_data8: sum=%h cout=%b want 00 0", sum8, cout8); n_fail++;
        end
        n_cmp++;
        if ({fa_a8, fa_b8, fa_cin8} !== 3'b000) begin
            $display("FAIL reset_fa8: fa=%b want 000", {fa_a8, fa_b8, fa_cin8}); n_fail++;
        end
        n_cmp++;
        if ({busy1, done1, sum1, cout1} !== 4'b0000) begin
            $display("FAIL reset_w1: busy,done,sum,cout=%b want 0000", {busy1, done1, sum1, cout1}); n_fail++;
        end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] a_t[3] = '{8'h3C, 8'hFF, 8'hA5};
        logic [7:0] b_t[3] = '{8'h42, 8'h01, 8'h5A};
        logic       c_t[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            int lat; logic [7:0] s; logic co, fc, bd, pok;
            logic [8:0] exp;
            exp = 9'(a_t[i]) + 9'(b_t[i]) + 9'(c_t[i]);
            do_op8(a_t[i], b_t[i], c_t[i], lat, s, co, fc, bd, pok);
            if (lat !== 9) begin
                $display("FAIL dir%0d_latency: got %0d want 9", i, lat); n_fail++;
            end
            n_cmp++;
            if ({co, s} !== exp) begin
                $display("FAIL dir%0d_result: got %b_%h want %b_%h", i, co, s, exp[8], exp[7:0]); n_fail++;
            end
            n_cmp++;
            if (fc !== c_t[i]) begin
                $display("FAIL dir%0d_first_fa_cin: got %b want %b", i, fc, c_t[i]); n_fail++;
            end
            n_cmp++;
            if (bd !== 1'b1 || pok !== 1'b1) begin
                $display("FAIL dir%0d_done_cycle: busy_at_done=%b post_ok=%b want 1 1", i, bd, pok); n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_start_ignored();
        int cyc; int lat; logic [7:0] s; logic co, fc, bd, pok;
        op_a8 = 8'h3C; op_b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 0;
        repeat (2) begin @(posedge clk); #1; cyc++; end
        // RUN cycle 3: new request with different operands
        op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1; cyc++;
        start8 = 1'b0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        if (done8 !== 1'b1 || cyc + 1 != 9) begin
            $display("FAIL ign_latency: done=%b after %0d cycles want 1 after 9", done8, cyc + 1); n_fail++;
        end
        n_cmp++;
        if ({cout8, sum8} !== 9'h07E) begin
            $display("FAIL ign_result: got %b_%h want 0_7e", cout8, sum8); n_fail++;
        end
        n_cmp++;
        @(posedge clk); #1;
        // First IDLE cycle after done: this start must be accepted
        do_op8(8'hA5, 8'h5A, 1'b1, lat, s, co, fc, bd, pok);
        if (lat !== 9 || {co, s} !== 9'h100) begin
            $display("FAIL ign_next_start: lat=%0d result=%b_%h want 9 1_00", lat, co, s); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_abort();
        int lat; logic [7:0] s; logic co, fc, bd, pok;
        logic saw_done;
        op_a8 = 8'h77; op_b8 = 8'h99; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        // RUN cycle 4
        abort8 = 1'b1;
        @(posedge clk); #1;
        abort8 = 1'b0;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || {fa_a8, fa_b8, fa_cin8} !== 3'b000) begin
            $display("FAIL abort_idle: busy=%b done=%b fa=%b want 0 0 000", busy8, done8, {fa_a8, fa_b8, fa_cin8}); n_fail++;
        end
        n_cmp++;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
        end
        if (saw_done !== 1'b0) begin
            $display("FAIL abort_no_done: activity seen=%b want 0", saw_done); n_fail++;
        end
        n_cmp++;
        do_op8(8'h12, 8'h34, 1'b1, lat, s, co, fc, bd, pok);
        if (lat !== 9 || {co, s} !== 9'h047) begin
            $display("FAIL abort_recover: lat=%0d result=%b_%h want 9 0_47", lat, co, s); n_fail++;
        end
        n_cmp++;
        // start together with abort in IDLE: start wins
        op_a8 = 8'h80; op_b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1; abort8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; abort8 = 1'b0;
        if (busy8 !== 1'b1) begin
            $display("FAIL abort_start_idle: busy=%b want 1", busy8); n_fail++;
        end
        n_cmp++;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        if (done8 !== 1'b1 || {cout8, sum8} !== 9'h101) begin
            $display("FAIL abort_start_result: done=%b result=%b_%h want 1 1_01", done8, cout8, sum8); n_fail++;
        end
        n_cmp++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [7:0] s; logic co, fc, bd, pok;
        logic saw_done;
        do_op8(8'hFF, 8'h01, 1'b0, lat, s, co, fc, bd, pok); // leaves cout=1
        op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        // RUN cycle 5
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            $display("FAIL rstrun_outputs: busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy8, done8, sum8, cout8); n_fail++;
        end
        n_cmp++;
        if ({fa_a8, fa_b8, fa_cin8} !== 3'b000) begin
            $display("FAIL rstrun_fa: fa=%b want 000", {fa_a8, fa_b8, fa_cin8}); n_fail++;
        end
        n_cmp++;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) saw_done = 1'b1;
        end
        if (saw_done !== 1'b0) begin
            $display("FAIL rstrun_no_done: done seen=%b want 0", saw_done); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_width1();
        int cyc;
        op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        if (busy1 !== 1'b1 || done1 !== 1'b0 || fa_cin1 !== 1'b1 || fa_a1 !== 1'b1) begin
            $display("FAIL w1_run: busy=%b done=%b fa_a=%b fa_cin=%b want 1 0 1 1", busy1, done1, fa_a1, fa_cin1); n_fail++;
        end
        n_cmp++;
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (done1 !== 1'b1 || cyc + 1 != 2) begin
            $display("FAIL w1_latency: done=%b after %0d cycles want 1 after 2", done1, cyc + 1); n_fail++;
        end
        n_cmp++;
        if (sum1 !== 1'b1 || cout1 !== 1'b1) begin
            $display("FAIL w1_result: sum=%b cout=%b want 1 1", sum1, cout1); n_fail++;
        end
        n_cmp++;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp;
            op_a1 = 1'(i); op_b1 = 1'(i >> 1); cin1 = 1'(i >> 2);
            exp = 2'(op_a1) + 2'(op_b1) + 2'(cin1);
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            @(posedge clk); #1;
            if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin
                $display("FAIL w1_case%0d: done=%b result=%b%b want 1 %b", i, done1, cout1, sum1, exp); n_fail++;
            end
            n_cmp++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 40; i++) begin
            int lat; logic [7:0] s; logic co, fc, bd, pok;
            logic [7:0] a, b; logic c; logic [8:0] exp;
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            if (i % 10 == 3) a = 8'hFF;
            if (i % 10 == 7) b = ~a;
            exp = 9'(a) + 9'(b) + 9'(c);
            do_op8(a, b, c, lat, s, co, fc, bd, pok);
            if (lat !== 9 || {co, s} !== exp || fc !== c || pok !== 1'b1) begin
                $display("FAIL rand%0d: a=%h b=%h c=%b lat=%0d result=%b_%h fa_cin0=%b post_ok=%b want 9 %b_%h %b 1",
                         i, a, b, c, lat, co, s, fc, pok, exp[8], exp[7:0], c);
                n_fail++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        start8 = 1'b0; abort8 = 1'b0; cin8 = 1'b0; op_a8 = '0; op_b8 = '0;
        start1 = 1'b0; abort1 = 1'b0; cin1 = 1'b0; op_a1 = '0; op_b1 = '0;
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_start_ignored();
        test_abort();
        test_reset_mid_run();
        test_width1();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
